// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the serial pattern detector.
// Every file in the detector slice imports this package.
package seq_det_pkg;

  localparam int         DEF_LEN     = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_OVERLAP = 1;
  localparam int         DEF_CNT_W   = 8;

  // Width needed to hold a matched-prefix length of 0..len-1 (at least one bit).
  function automatic int stateWidth(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/seq_detector_n_if.sv
// Data, control and status bundle of the pattern detector.
// The driver uses the master side and the detector uses the slave side.
interface seq_detector_n_if
  import seq_det_pkg::*;
#(
  parameter int LEN   = DEF_LEN,
  parameter int CNT_W = DEF_CNT_W,
  localparam int SW   = stateWidth(LEN)
);

  logic             en;
  logic             x;
  logic             load;
  logic [LEN-1:0]   pat_in;
  logic             clr_cnt;
  logic             z;
  logic             z_q;
  logic [CNT_W-1:0] match_cnt;
  logic [SW-1:0]    prog;

  modport master (
    output en, x, load, pat_in, clr_cnt,
    input  z, z_q, match_cnt, prog
  );

  modport slave (
    input  en, x, load, pat_in, clr_cnt,
    output z, z_q, match_cnt, prog
  );

endinterface

// File: rtl/seq_fallback.sv
// Failure fallback: the longest proper suffix of (pattern prefix of length state, xBit)
// that is also a prefix of the pattern. The result is purely combinational.
module seq_fallback
  import seq_det_pkg::*;
#(
  parameter int LEN = DEF_LEN,
  parameter int SW  = stateWidth(DEF_LEN)
) (
  input  logic [LEN-1:0] pattern,
  input  logic [SW-1:0]  state,
  input  logic           xBit,
  output logic [SW-1:0]  fallback
);

  // Bit idx of the pattern. An out-of-range idx reads as 0 and is never relied on.
  function automatic logic patBit(input logic [LEN-1:0] p, input int idx);
    return |(p & (LEN'(1) << idx));
  endfunction

  // Try every candidate length in ascending order, so the longest candidate that fits wins.
  always_comb begin
    int   k;
    logic ok;
    fallback = '0;
    k        = int'(state);
    ok       = 1'b0;
    for (int j = 1; j < LEN; j++) begin
      ok = (j <= k) && (xBit == patBit(pattern, LEN - j));
      for (int m = 0; m < LEN - 2; m++) begin
        if (m < j - 1 &&
            patBit(pattern, LEN - 1 - m) != patBit(pattern, LEN - 1 - (k - j + 1 + m)))
          ok = 1'b0;
      end
      if (ok)
        fallback = SW'(j);
    end
  end

endmodule

// File: rtl/seq_detector_n.sv
// Serial detector for a loadable LEN-bit pattern. It gives a Mealy match pulse,
// a registered copy of that pulse, and a saturating count of matches.
module seq_detector_n
  import seq_det_pkg::*;
#(
  parameter int             LEN     = DEF_LEN,
  parameter logic [LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int             OVERLAP = DEF_OVERLAP,
  parameter int             CNT_W   = DEF_CNT_W,
  localparam int            SW      = stateWidth(LEN)
) (
  input logic             clk,
  input logic             rst,
  seq_detector_n_if.slave bus
);

  localparam logic [SW-1:0]    LAST    = SW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LEN-1:0]   patReg;
  logic [SW-1:0]    state;
  logic [SW-1:0]    fbNext;
  logic [SW-1:0]    border;
  logic [CNT_W-1:0] cnt;
  logic             zReg;
  logic             expBit;
  logic             atEnd;
  logic             hit;
  logic             zComb;

  seq_fallback #(.LEN(LEN), .SW(SW)) uNextFallback (
    .pattern  (patReg),
    .state    (state),
    .xBit     (bus.x),
    .fallback (fbNext)
  );

  // The border of the full pattern is the fallback from the last state when the final bit matches.
  seq_fallback #(.LEN(LEN), .SW(SW)) uBorder (
    .pattern  (patReg),
    .state    (LAST),
    .xBit     (patReg[0]),
    .fallback (border)
  );

  assign expBit = |(patReg & (LEN'(1) << (LEN - 1 - int'(state))));
  assign atEnd  = (state == LAST);
  assign hit    = (bus.x == expBit);
  assign zComb  = !rst && !bus.load && bus.en && atEnd && hit;

  assign bus.z         = zComb;
  assign bus.z_q       = zReg;
  assign bus.match_cnt = cnt;
  assign bus.prog      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= '0;
      patReg <= PATTERN;
      cnt    <= '0;
      zReg   <= 1'b0;
    end else begin
      zReg <= zComb;
      if (bus.load) begin
        patReg <= bus.pat_in;
        state  <= '0;
      end else if (bus.en) begin
        if (hit)
          state <= atEnd ? ((OVERLAP != 0) ? border : '0) : state + 1'b1;
        else
          state <= fbNext;
      end
      if (bus.clr_cnt)
        cnt <= '0;
      else if (zComb && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_n.sv
// Checks three detector variants (defaults, non-overlapping, 2-bit counter) against
// a model that keeps the received bit history and tests it arithmetically.
module tb_seq_detector_n;
  import seq_det_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       load = 1'b0;
  logic [3:0] patIn = 4'b0000;
  logic       clrCnt = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  seq_detector_n_if                ifA ();
  seq_detector_n_if                ifB ();
  seq_detector_n_if #(.CNT_W(2))   ifC ();

  seq_detector_n                dutA (.clk(clk), .rst(rst), .bus(ifA));
  seq_detector_n #(.OVERLAP(0)) dutB (.clk(clk), .rst(rst), .bus(ifB));
  seq_detector_n #(.CNT_W(2))   dutC (.clk(clk), .rst(rst), .bus(ifC));

  assign ifA.en = en;      assign ifB.en = en;      assign ifC.en = en;
  assign ifA.x = x;        assign ifB.x = x;        assign ifC.x = x;
  assign ifA.load = load;  assign ifB.load = load;  assign ifC.load = load;
  assign ifA.pat_in = patIn; assign ifB.pat_in = patIn; assign ifC.pat_in = patIn;
  assign ifA.clr_cnt = clrCnt; assign ifB.clr_cnt = clrCnt; assign ifC.clr_cnt = clrCnt;

  logic       zAct [3];
  logic       zqAct [3];
  logic [1:0] progAct [3];
  logic [7:0] cntAct [3];
  assign zAct[0] = ifA.z;   assign zAct[1] = ifB.z;   assign zAct[2] = ifC.z;
  assign zqAct[0] = ifA.z_q; assign zqAct[1] = ifB.z_q; assign zqAct[2] = ifC.z_q;
  assign progAct[0] = ifA.prog; assign progAct[1] = ifB.prog; assign progAct[2] = ifC.prog;
  assign cntAct[0] = ifA.match_cnt; assign cntAct[1] = ifB.match_cnt;
  assign cntAct[2] = {6'b000000, ifC.match_cnt};

  always #5 clk = ~clk;

  // Reference state per variant: bits received since the last restart and the running count.
  int         histLen [3] = '{0, 0, 0};
  logic [7:0] histVal [3] = '{8'h00, 8'h00, 8'h00};
  int         cntModel [3] = '{0, 0, 0};
  bit         zqModel [3] = '{1'b0, 1'b0, 1'b0};
  logic [3:0] patModel = 4'b1011;
  int         cntMax [3] = '{255, 255, 3};
  int         overlapOn [3] = '{1, 0, 1};

  // Longest history suffix of length below 4 that equals the start of the pattern.
  function automatic int modelProg(input int h, input logic [7:0] v, input logic [3:0] p);
    for (int j = 3; j >= 0; j--)
      if (j <= h && ((int'(v) & ((1 << j) - 1)) == (int'(p) >> (4 - j))))
        return j;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit xi, input bit ld,
                               input logic [3:0] pi, input bit clr);
    bit         zExp [3];
    logic [7:0] hvNext [3];
    @(negedge clk);
    rst = r; en = e; x = xi; load = ld; patIn = pi; clrCnt = clr;
    for (int i = 0; i < 3; i++) begin
      hvNext[i] = {histVal[i][6:0], xi};
      zExp[i]   = !r && !ld && e && (histLen[i] + 1 >= 4) && (hvNext[i][3:0] == patModel);
    end
    #1;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("z[%0d]", i), zAct[i], zExp[i]);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        histLen[i] = 0; histVal[i] = 8'h00; cntModel[i] = 0; zqModel[i] = 1'b0;
      end else begin
        zqModel[i] = zExp[i];
        if (ld) begin
          histLen[i] = 0;
        end else if (e) begin
          histVal[i] = hvNext[i];
          histLen[i] = (histLen[i] + 1 > 7) ? 7 : histLen[i] + 1;
          if (zExp[i] && overlapOn[i] == 0)
            histLen[i] = 0;
        end
        if (clr)
          cntModel[i] = 0;
        else if (zExp[i] && cntModel[i] < cntMax[i])
          cntModel[i]++;
      end
    end
    if (r)
      patModel = 4'b1011;
    else if (ld)
      patModel = pi;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("prog[%0d]", i), progAct[i], modelProg(histLen[i], histVal[i], patModel));
      checkOutput($sformatf("z_q[%0d]", i), zqAct[i], zqModel[i]);
      checkOutput($sformatf("match_cnt[%0d]", i), cntAct[i], cntModel[i]);
    end
  endtask

  task automatic feedBits(input logic [15:0] b, input int n);
    for (int i = n - 1; i >= 0; i--)
      applyStimulus(1'b0, 1'b1, b[i], 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    doReset();
    feedBits(16'b1011011, 7);
    checkOutput("ovl_cnt", cntAct[0], 2);
    checkOutput("noovl_cnt", cntAct[1], 1);
    checkOutput("noovl_prog", progAct[1], 1);

    doReset();
    feedBits(16'b1010, 4);
    checkOutput("fallback_prog", progAct[0], 2);
    feedBits(16'b11, 2);

    doReset();
    feedBits(16'b10, 2);
    checkOutput("preload_prog", progAct[0], 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    checkOutput("load_prog", progAct[0], 0);
    feedBits(16'b0110, 4);
    checkOutput("loaded_cnt", cntAct[0], 1);

    doReset();
    feedBits(16'b1011011011011011, 16);
    checkOutput("sat_cnt", cntAct[2], 3);
    feedBits(16'b01, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    checkOutput("clr_cnt", cntAct[2], 0);

    doReset();
    feedBits(16'b101, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    feedBits(16'b1, 1);
    checkOutput("rst_prog", progAct[0], 1);
    checkOutput("rst_cnt", cntAct[0], 0);

    for (int n = 0; n < 400; n++)
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                    $urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 15) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detector_n.md
SEQ_DETECTOR_N -- requirements
Module: seq_detector_n

Interface
REQ-001 The module SHALL have parameter LEN, default 4, meaning pattern length in bits (LEN >= 2).
REQ-002 The module SHALL have parameter PATTERN, default 4'b1011, meaning the pattern loaded at reset; PATTERN[LEN-1] is the first bit received.
REQ-003 The module SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches allowed and 0 = restart from empty after a match.
REQ-004 The module SHALL have parameter CNT_W, default 8, meaning the match counter width.
REQ-005 The module SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-006 The module SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 The module SHALL have port en, input, 1, meaning x is valid this cycle.
REQ-008 The module SHALL have port x, input, 1, meaning the serial data bit.
REQ-009 The module SHALL have port load, input, 1, meaning replace the pattern register with pat_in.
REQ-010 The module SHALL have port pat_in, input, LEN, meaning the new pattern, MSB first.
REQ-011 The module SHALL have port clr_cnt, input, 1, meaning clear match_cnt.
REQ-012 The module SHALL have port z, output, 1, meaning a Mealy match pulse, combinational in the cycle the last pattern bit is presented.
REQ-013 The module SHALL have port z_q, output, 1, meaning z registered one cycle later.
REQ-014 The module SHALL have port match_cnt, output, CNT_W, meaning the saturating count of matches.
REQ-015 The module SHALL have port prog, output, SW = max(1, clog2(LEN)), meaning the current state (matched-prefix length).

Function
REQ-016 The state SHALL equal the length of the longest received suffix that is a proper prefix of the pattern; legal range is 0..LEN-1, and LEN is never held.
REQ-017 When en=1 and state k < LEN-1, the next state SHALL be k+1 if x == pat[LEN-1-k], else the longest proper suffix of (prefix_k, x) that is also a pattern prefix (failure fallback, computed from the live pattern register).
REQ-018 When en=1, state == LEN-1 and x == pat[0], z SHALL be 1 in that same cycle; the next state SHALL be the longest proper border of the full pattern if OVERLAP=1, else 0.
REQ-019 When en=1, state == LEN-1 and x != pat[0], z SHALL be 0 and the next state SHALL be given by the fallback of REQ-017.
REQ-020 When en=0, the state SHALL hold and z SHALL be 0.
REQ-021 When load=1, the pattern register SHALL take pat_in, the state SHALL go to 0, and z SHALL be 0 that cycle; load has priority over en, and x is ignored that cycle.
REQ-022 match_cnt SHALL increment by 1 on each cycle with z=1 and saturate at 2^CNT_W-1, with no wrap-around.
REQ-023 When clr_cnt=1, the next match_cnt SHALL be 0 even if z=1 in the same cycle.
REQ-024 z_q SHALL equal the value z had on the previous cycle.
REQ-025 Priority SHALL be rst > load > en for the state; rst > clr_cnt > increment for the counter.

Reset
REQ-026 On rst=1 at a clock edge, the state SHALL become 0, the pattern register PATTERN, match_cnt 0 and z_q 0.
REQ-027 While rst=1, z SHALL be forced to 0; rst asserted mid-pattern SHALL discard partial progress.

Structure
REQ-028 The default LEN, PATTERN, OVERLAP and CNT_W values, plus the SW width function, SHALL reside in the shared package seq_det_pkg.
REQ-029 The failure-fallback computation SHALL be the sub-module seq_fallback (combinational; inputs: pattern, state, bit; output: fallback state), instantiated once for the next-state path and once for the overlap border.

Verification
REQ-030 Defaults, stream 1,0,1,1,0,1,1 with en=1 -> z=1 on bits 4 and 7 only; match_cnt=2.
REQ-031 OVERLAP=0, same stream -> z=1 on bit 4 only; prog after bit 7 = 1; match_cnt=1.
REQ-032 Stream 1,0,1,0,1,1 -> prog after bit 4 = 2; z=1 on bit 6 only.
REQ-033 After 1,0 (prog=2), drive load=1 with pat_in=4'b0110 -> prog=0 and z=0; then 0,1,1,0 -> z=1 on the 4th bit.
REQ-034 CNT_W=2, five matches -> match_cnt=3; then clr_cnt=1 coincident with a match -> match_cnt=0.
REQ-035 Stream 1,0,1 then rst=1 for one cycle with x=1, then 1 -> z=0 throughout; prog=1; match_cnt=0.
